// File: rtl/datapath_pkg.sv
// Shared constants for the datapath: widths, ALU opcodes, branch condition codes
// and the condition evaluator used by the CON flip-flop.
package datapath_pkg;

  localparam int WORD_W   = 32;
  localparam int DWORD_W  = 64;
  localparam int NUM_REGS = 16;
  localparam int MEM_DEPTH = 512;
  localparam int MEM_AW   = 9;
  localparam int REG_AW   = 4;

  typedef enum logic [4:0] {
    OP_LD   = 5'b00000,
    OP_LDI  = 5'b00001,
    OP_ST   = 5'b00010,
    OP_ADD  = 5'b00011,
    OP_SUB  = 5'b00100,
    OP_SHR  = 5'b00101,
    OP_SHRA = 5'b00110,
    OP_SHL  = 5'b00111,
    OP_ROR  = 5'b01000,
    OP_ROL  = 5'b01001,
    OP_AND  = 5'b01010,
    OP_OR   = 5'b01011,
    OP_ADDI = 5'b01100,
    OP_ANDI = 5'b01101,
    OP_ORI  = 5'b01110,
    OP_DIV  = 5'b01111,
    OP_MUL  = 5'b10000,
    OP_NEG  = 5'b10001,
    OP_NOT  = 5'b10010,
    OP_BRZR = 5'b10011
  } opcode_t;

  typedef enum logic [1:0] {
    COND_ZERO    = 2'b00,
    COND_NONZERO = 2'b01,
    COND_POS     = 2'b10,
    COND_NEG     = 2'b11
  } cond_t;

  function automatic logic eval_cond(input logic [1:0] c2, input logic [WORD_W-1:0] value);
    logic result;
    result = 1'b0;
    case (c2)
      COND_ZERO:    result = (value == '0);
      COND_NONZERO: result = (value != '0);
      COND_POS:     result = !value[WORD_W-1] && (value != '0);
      COND_NEG:     result = value[WORD_W-1];
      default:      result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/datapath_reg32.sv
// 32-bit load-enabled register used for PC and every dedicated datapath register.
module reg32
  import datapath_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              enable,
  input  logic [WORD_W-1:0] D,
  output logic [WORD_W-1:0] BusMuxIn
);

  // NOTE: state is updated with <= so every register samples pre-edge values together.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) BusMuxIn <= '0;
    else if (enable) BusMuxIn <= D;
  end

endmodule

// File: rtl/datapath.sv
// Single-bus CPU datapath: register file, dedicated registers, ALU, CON logic, 512x32 memory.
// Define MUL_DIV_EN to enable the signed mul/div ALU operations.
module datapath
  import datapath_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic              PCout,
  input  logic              MDRout,
  input  logic              Zhighout,
  input  logic              Zlowout,
  input  logic              HIout,
  input  logic              LOout,
  input  logic              InPortout,
  input  logic              Cout,
  input  logic              Rout,
  input  logic              BAout,
  input  logic              PCin,
  input  logic              IRin,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Yin,
  input  logic              Zhighin,
  input  logic              Zlowin,
  input  logic              HIin,
  input  logic              LOin,
  input  logic              OutPortin,
  input  logic              InPortin,
  input  logic              Rin,
  input  logic              CONin,
  input  logic              Read,
  input  logic              Write,
  input  logic              IncPC,
  input  logic              Gra,
  input  logic              Grb,
  input  logic              Grc,
  input  logic              JAL_flag,
  input  logic [WORD_W-1:0] InPort_input,
  output logic [WORD_W-1:0] OutPort_out,
  output logic              CON
);

  logic [WORD_W-1:0]  bus;
  logic [WORD_W-1:0]  pc_q, ir_q, mar_q, mdr_q, y_q, zhigh_q, zlow_q, hi_q, lo_q, inport_q;
  logic [WORD_W-1:0]  pc_d, mdr_d;
  logic [DWORD_W-1:0] alu_c;
  logic [REG_AW-1:0]  sel, wr_sel;
  logic [WORD_W-1:0]  regs [NUM_REGS];
  logic [WORD_W-1:0]  mem  [MEM_DEPTH];

  logic [4:0]        opcode;
  logic [REG_AW-1:0] ra, rb, rc;
  logic [1:0]        c2;
  logic [WORD_W-1:0] c_sext;

  assign opcode = ir_q[31:27];
  assign ra     = ir_q[26:23];
  assign rb     = ir_q[22:19];
  assign rc     = ir_q[18:15];
  assign c2     = ir_q[20:19];
  assign c_sext = {{13{ir_q[18]}}, ir_q[18:0]};

  // InPortin is reserved; upper MAR bits lie beyond the memory.
  logic [23:0] unused_bits;
  assign unused_bits = {InPortin, mar_q[WORD_W-1:MEM_AW]};

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = '0;
    if (Gra)      sel = ra;
    else if (Grb) sel = rb;
    else if (Grc) sel = rc;
  end

  assign wr_sel = (JAL_flag && Rin) ? REG_AW'(15) : sel;

  always_comb begin
    bus = '0;
    if (PCout)          bus = pc_q;
    else if (MDRout)    bus = mdr_q;
    else if (Zhighout)  bus = zhigh_q;
    else if (Zlowout)   bus = zlow_q;
    else if (HIout)     bus = hi_q;
    else if (LOout)     bus = lo_q;
    else if (InPortout) bus = inport_q;
    else if (Cout)      bus = c_sext;
    else if (Rout)      bus = regs[sel];
    else if (BAout)     bus = (sel == '0) ? '0 : regs[sel];
  end

  // ALU: A is Y, B is the bus. Only mul/div use the upper half.
  logic [WORD_W-1:0]  shra_res;
  logic [DWORD_W-1:0] rot;
  always_comb begin
    alu_c    = '0;
    rot      = '0;
    shra_res = $signed(y_q) >>> bus[4:0];
    case (opcode)
      OP_LD, OP_LDI, OP_ST, OP_ADD, OP_ADDI, OP_BRZR:
                alu_c = {32'b0, y_q + bus};
      OP_SUB:   alu_c = {32'b0, y_q - bus};
      OP_SHR:   alu_c = {32'b0, y_q >> bus[4:0]};
      OP_SHRA:  alu_c = {32'b0, shra_res};
      OP_SHL:   alu_c = {32'b0, y_q << bus[4:0]};
      OP_ROR: begin
        rot   = {y_q, y_q} >> bus[4:0];
        alu_c = {32'b0, rot[31:0]};
      end
      OP_ROL: begin
        rot   = {y_q, y_q} << bus[4:0];
        alu_c = {32'b0, rot[63:32]};
      end
      OP_AND, OP_ANDI: alu_c = {32'b0, y_q & bus};
      OP_OR,  OP_ORI:  alu_c = {32'b0, y_q | bus};
      OP_NEG:   alu_c = {32'b0, -bus};
      OP_NOT:   alu_c = {32'b0, ~bus};
`ifdef MUL_DIV_EN
      OP_MUL:   alu_c = $signed({{32{y_q[31]}}, y_q}) * $signed({{32{bus[31]}}, bus});
      OP_DIV: begin
        if (bus != '0)
          alu_c = {32'($signed(y_q) % $signed(bus)), 32'($signed(y_q) / $signed(bus))};
      end
`else
      OP_MUL, OP_DIV: alu_c = '0;
`endif
      default:  alu_c = '0;
    endcase
  end

  assign pc_d  = IncPC ? pc_q + 32'd1 : bus;
  assign mdr_d = Read ? mem[mar_q[MEM_AW-1:0]] : bus;

  reg32 PC      (.clock(clock), .clear(clear), .enable(PCin),      .D(pc_d),            .BusMuxIn(pc_q));
  reg32 IR      (.clock(clock), .clear(clear), .enable(IRin),      .D(bus),             .BusMuxIn(ir_q));
  reg32 MAR     (.clock(clock), .clear(clear), .enable(MARin),     .D(bus),             .BusMuxIn(mar_q));
  reg32 MDR     (.clock(clock), .clear(clear), .enable(MDRin),     .D(mdr_d),           .BusMuxIn(mdr_q));
  reg32 Y       (.clock(clock), .clear(clear), .enable(Yin),       .D(bus),             .BusMuxIn(y_q));
  reg32 Zhigh   (.clock(clock), .clear(clear), .enable(Zhighin),   .D(alu_c[63:32]),    .BusMuxIn(zhigh_q));
  reg32 Zlow    (.clock(clock), .clear(clear), .enable(Zlowin),    .D(alu_c[31:0]),     .BusMuxIn(zlow_q));
  reg32 HI      (.clock(clock), .clear(clear), .enable(HIin),      .D(bus),             .BusMuxIn(hi_q));
  reg32 LO      (.clock(clock), .clear(clear), .enable(LOin),      .D(bus),             .BusMuxIn(lo_q));
  reg32 InPort  (.clock(clock), .clear(clear), .enable(1'b1),      .D(InPort_input),    .BusMuxIn(inport_q));
  reg32 OutPort (.clock(clock), .clear(clear), .enable(OutPortin), .D(bus),             .BusMuxIn(OutPort_out));

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (Rin) begin
      regs[wr_sel] <= bus;
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)     CON <= 1'b0;
    else if (CONin) CON <= eval_cond(c2, bus);
  end

  // NOTE: memory has no reset; its contents must survive clear.
  always_ff @(posedge clock) begin
    if (Write) mem[mar_q[MEM_AW-1:0]] <= mdr_q;
  end

endmodule

// File: tb/tb_datapath.sv
// Directed self-checking bench for datapath; expected values are hand-computed.
// Mul/div expectations follow the MUL_DIV_EN build option.
module tb_datapath;

  logic clock = 1'b0;
  logic clear = 1'b1;
  logic PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout, Rout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, InPortin, Rin, CONin;
  logic Read, Write, IncPC, Gra, Grb, Grc, JAL_flag;
  logic [31:0] InPort_input = '0;
  logic [31:0] OutPort_out;
  logic        CON;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .HIin(HIin), .LOin(LOin),
    .OutPortin(OutPortin), .InPortin(InPortin), .Rin(Rin), .CONin(CONin),
    .Read(Read), .Write(Write), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .JAL_flag(JAL_flag),
    .InPort_input(InPort_input), .OutPort_out(OutPort_out), .CON(CON)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout, Rout, BAout} = '0;
    {PCin, IRin, MARin, MDRin, Yin, Zhighin, Zlowin, HIin, LOin, OutPortin, InPortin, Rin, CONin} = '0;
    {Read, Write, IncPC, Gra, Grb, Grc, JAL_flag} = '0;
  endtask

  // Apply the currently driven controls for one edge, sample 1 time unit later.
  task automatic tick();
    @(posedge clock);
    #1;
    idle();
  endtask

  // Let InPort capture v, then put it on the bus; caller adds the load enable.
  task automatic via_inport(input logic [31:0] v);
    InPort_input = v;
    tick();
    InPortout = 1'b1;
  endtask

  task automatic load_ir(input logic [31:0] v);
    via_inport(v);
    IRin = 1'b1;
    tick();
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [31:0] v);
    load_ir({5'b0, idx, 23'b0});
    via_inport(v);
    Gra = 1'b1; Rin = 1'b1;
    tick();
  endtask

  task automatic alu_op(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    load_ir({op, ra, rb, rc, 15'b0});
    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
    tick();
    Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
    tick();
    Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
    tick();
  endtask

  task automatic cond_test(input logic [1:0] c2, input logic exp, input string tag);
    load_ir({5'b10011, 4'd4, 2'b00, c2, 19'b0});
    Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
    tick();
    check(tag, {31'b0, CON}, {31'b0, exp});
  endtask

  logic [4:0]  alu_ops [10] = '{5'b00011, 5'b00100, 5'b01010, 5'b01011, 5'b00111,
                                5'b01000, 5'b01001, 5'b10001, 5'b10010, 5'b11111};
  logic [31:0] alu_exp [10] = '{32'd12, 32'hFFFFFFFE, 32'd5, 32'd7, 32'h00000280,
                                32'h0A000000, 32'h00000280, 32'hFFFFFFF9, 32'hFFFFFFF8, 32'd0};

  initial begin
    idle();
    #1 clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_pc", dut.PC.BusMuxIn, 32'd0);
    check("rst_ir", dut.IR.BusMuxIn, 32'd0);
    check("rst_outport", OutPort_out, 32'd0);
    check("rst_con", {31'b0, CON}, 32'd0);
    check("rst_r3", dut.regs[3], 32'd0);
    @(negedge clock) clear = 1'b1;

    // Preload mem[18] and PC through the bus.
    via_inport(32'd18); MARin = 1'b1; tick();
    via_inport(32'hB1800000); MDRin = 1'b1; tick();
    Write = 1'b1; tick();
    via_inport(32'd18); PCin = 1'b1; tick();
    check("pc_preset", dut.PC.BusMuxIn, 32'd18);

    // Fetch followed by "in R3".
    InPort_input = 32'd68; tick();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; tick();
    check("fetch_mar", dut.MAR.BusMuxIn, 32'd18);
    check("fetch_pc", dut.PC.BusMuxIn, 32'd19);
    Read = 1'b1; MDRin = 1'b1; tick();
    check("fetch_mdr", dut.MDR.BusMuxIn, 32'hB1800000);
    MDRout = 1'b1; IRin = 1'b1; tick();
    check("fetch_ir", dut.IR.BusMuxIn, 32'hB1800000);
    Gra = 1'b1; Rin = 1'b1; InPortout = 1'b1; tick();
    check("in_r3", dut.regs[3], 32'd68);

    // Asynchronous clear between edges.
    clear = 1'b0;
    #2;
    check("aclr_pc", dut.PC.BusMuxIn, 32'd0);
    check("aclr_r3", dut.regs[3], 32'd0);
    check("aclr_ir", dut.IR.BusMuxIn, 32'd0);
    check("aclr_outport", OutPort_out, 32'd0);
    check("aclr_mem18", dut.mem[18], 32'hB1800000);
    @(negedge clock) clear = 1'b1;

    // ALU with R1=5, R2=7 into R3.
    set_reg(4'd1, 32'd5);
    set_reg(4'd2, 32'd7);
    for (int i = 0; i < 10; i++) begin
      alu_op(alu_ops[i], 4'd3, 4'd1, 4'd2);
      check($sformatf("alu_op%b", alu_ops[i]), dut.regs[3], alu_exp[i]);
    end
    check("add_zhigh", dut.Zhigh.BusMuxIn, 32'd0);

    // mul: -3 * 4
    set_reg(4'd1, 32'hFFFFFFFD);
    set_reg(4'd2, 32'd4);
    alu_op(5'b10000, 4'd3, 4'd1, 4'd2);
`ifdef MUL_DIV_EN
    check("mul_lo", dut.Zlow.BusMuxIn, 32'hFFFFFFF4);
    check("mul_hi", dut.Zhigh.BusMuxIn, 32'hFFFFFFFF);
`else
    check("mul_lo", dut.Zlow.BusMuxIn, 32'd0);
    check("mul_hi", dut.Zhigh.BusMuxIn, 32'd0);
`endif
    // div: 7 / -3 -> q=-2, r=1
    set_reg(4'd1, 32'd7);
    set_reg(4'd2, 32'hFFFFFFFD);
    alu_op(5'b01111, 4'd3, 4'd1, 4'd2);
`ifdef MUL_DIV_EN
    check("div_q", dut.Zlow.BusMuxIn, 32'hFFFFFFFE);
    check("div_r", dut.Zhigh.BusMuxIn, 32'd1);
`else
    check("div_q", dut.Zlow.BusMuxIn, 32'd0);
    check("div_r", dut.Zhigh.BusMuxIn, 32'd0);
`endif
    set_reg(4'd2, 32'd0);
    alu_op(5'b01111, 4'd3, 4'd1, 4'd2);
    check("div0_q", dut.Zlow.BusMuxIn, 32'd0);
    check("div0_r", dut.Zhigh.BusMuxIn, 32'd0);

    // BAout reads R0 as zero; Rout does not.
    set_reg(4'd0, 32'h55);
    load_ir(32'd0);
    Gra = 1'b1; BAout = 1'b1; OutPortin = 1'b1; tick();
    check("baout_r0", OutPort_out, 32'd0);
    Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; tick();
    check("rout_r0", OutPort_out, 32'h55);

    // JAL_flag redirects the write to R15.
    set_reg(4'd3, 32'h11);
    load_ir({5'b0, 4'd3, 23'b0});
    via_inport(32'h99); Gra = 1'b1; Rin = 1'b1; JAL_flag = 1'b1; tick();
    check("jal_r15", dut.regs[15], 32'h99);
    check("jal_r3", dut.regs[3], 32'h11);

    // CON conditions and out.
    set_reg(4'd4, 32'd0);
    cond_test(2'b00, 1'b1, "con_zero");
    Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; tick();
    check("out_r4", OutPort_out, 32'd0);
    cond_test(2'b01, 1'b0, "con_nz_on0");
    set_reg(4'd4, 32'h80000000);
    cond_test(2'b11, 1'b1, "con_neg");
    cond_test(2'b10, 1'b0, "con_pos_onneg");
    set_reg(4'd4, 32'd5);
    cond_test(2'b10, 1'b1, "con_pos");

    // Memory store then load.
    via_inport(32'd40); MARin = 1'b1; tick();
    via_inport(32'h1234); MDRin = 1'b1; tick();
    Write = 1'b1; tick();
    check("mem_store", dut.mem[40], 32'h1234);
    via_inport(32'd0); MDRin = 1'b1; tick();
    check("mdr_cleared", dut.MDR.BusMuxIn, 32'd0);
    Read = 1'b1; MDRin = 1'b1; tick();
    check("mem_load", dut.MDR.BusMuxIn, 32'h1234);

    // Cout sign extension, bus priority, undriven bus.
    load_ir(32'h00040000);
    Cout = 1'b1; OutPortin = 1'b1; tick();
    check("cout_sext", OutPort_out, 32'hFFFC0000);
    via_inport(32'h77); PCin = 1'b1; tick();
    PCout = 1'b1; MDRout = 1'b1; OutPortin = 1'b1; tick();
    check("bus_priority", OutPort_out, 32'h77);
    OutPortin = 1'b1; tick();
    check("bus_idle", OutPort_out, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
